mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the fetch stage (instruction
//  reads) and the load/store stage (data reads and writes) of the riscv core.
//  Runs a small FSM with one outstanding access. Data requests have priority;
//  a starvation counter guarantees fetch progress. Returns read data to the owner.
// PARAMETERS
//  ADDR_W      32  address width, all address ports
//  DATA_W      32  data width; byte-enable width is DATA_W/8
//  MEM_LAT     1   memory read latency in cycles (legal 1..4)
//  STARVE_MAX  4   max consecutive data grants while if_req_i is pending (>=1)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  if_req_i     in   1         fetch read request; held until if_gnt_o
//  if_addr_i    in   ADDR_W    fetch address (pc)
//  if_gnt_o     out  1         fetch request accepted this cycle
//  if_rvalid_o  out  1         if_rdata_o valid, 1-cycle pulse
//  if_rdata_o   out  DATA_W    fetched instruction
//  d_req_i      in   1         data request; held until d_gnt_o
//  d_we_i       in   1         1=store, 0=load
//  d_be_i       in   DATA_W/8  store byte enables
//  d_addr_i     in   ADDR_W    data address (alu result)
//  d_wdata_i    in   DATA_W    store data
//  d_gnt_o      out  1         data request accepted this cycle
//  d_rvalid_o   out  1         load data valid / store done, 1-cycle pulse
//  d_rdata_o    out  DATA_W    load data (0 for stores)
//  mem_en_o     out  1         memory access strobe
//  mem_we_o     out  1         memory write enable
//  mem_be_o     out  DATA_W/8  memory byte enables
//  mem_addr_o   out  ADDR_W    memory address
//  mem_wdata_o  out  DATA_W    memory write data
//  mem_rdata_i  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_en_o
//  busy_o       out  1         access outstanding (state BUSY)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, lat_cnt=0, starve_cnt=0, owner=FETCH.
//    All outputs 0. An access in flight is dropped: no rvalid after release.
//  - FSM: IDLE -> BUSY on any grant. BUSY -> IDLE when lat_cnt reaches MEM_LAT
//    with no new grant. BUSY -> BUSY on a back-to-back grant in that cycle.
//  - Grant eligibility: in IDLE, or in BUSY in the response cycle. Never otherwise.
//    Requests are ignored while not eligible and are not stored.
//  - Arbitration: choose data if d_req_i, unless if_req_i && starve_cnt==STARVE_MAX.
//    Otherwise choose fetch if if_req_i. At most one gnt per cycle.
//  - starve_cnt: +1 on a data grant while if_req_i=1 (saturates).
//    Cleared on a fetch grant or whenever if_req_i=0.
//  - Grant cycle t is combinational from the requests:
//      gnt high; mem_en_o=1; mem_addr_o/we/be/wdata = winner's inputs.
//      Fetch drives we=0, be=all-ones, wdata=0.
//    At t, owner<=winner and lat_cnt<=1. lat_cnt increments each cycle in BUSY.
//  - Response at cycle t+MEM_LAT (lat_cnt==MEM_LAT): owner's rvalid_o=1 for one cycle.
//    Owner's rdata_o=mem_rdata_i; store response gives d_rdata_o=0.
//    Both rdata_o are 0 when not valid.
//  - Throughput: one access per MEM_LAT cycles under continuous requests.
//  - mem_* outputs are 0 in every non-grant cycle.
//  - busy_o=1 from cycle t+1 through t+MEM_LAT inclusive, then stays 1 on a back-to-back grant.
//  - Addresses are forwarded unchanged; no alignment or range checks.
// TESTING
//  1 Reset: drive rst=0 with requests active -> all outputs 0, no gnt.
//    Release -> first grant on next request.
//  2 Fetch only, MEM_LAT=2: if_req_i=1, addr 0x10, mem returns 0x00500093
//    -> if_gnt_o at t, mem_en_o at t, if_rvalid_o at t+2 with 0x00500093.
//  3 Simultaneous if_req_i and d_req_i (load 0x100) -> d_gnt_o first.
//    Fetch granted in the d_rvalid_o cycle; if_rvalid_o MEM_LAT later.
//  4 Starvation, STARVE_MAX=4: d_req_i and if_req_i held high
//    -> grants D,D,D,D,F,D,D,D,D,F,...
//  5 Store d_we_i=1, be=0011, addr 0x20, wdata 0xDEADBEEF -> mem_we_o=1, mem_be_o=0011
//    -> d_rvalid_o pulse with d_rdata_o=0; later load of 0x20 returns the stored bytes.
//  6 Reset mid-access: rst=0 during BUSY (MEM_LAT=3) -> busy_o=0 immediately.
//    No rvalid on either port after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store.
// One access outstanding at a time; data wins unless fetch has been starved STARVE_MAX times.
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   output logic                d_gnt_o,
   output logic                d_rvalid_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                mem_en_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                busy_o
);

   localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
   localparam logic [2:0] LatMax = 3'(MEM_LAT);
   localparam logic [SC_W-1:0] StarveMax = SC_W'(STARVE_MAX);

   typedef enum logic {StIdle, StBusy} state_e;
   typedef enum logic {OwnFetch, OwnData} owner_e;

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            store_q, store_d;
   logic [2:0]      lat_cnt_q, lat_cnt_d;
   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

   logic resp;
   logic eligible;
   logic starved;
   logic data_win;
   logic fetch_win;

   always_comb begin
      resp      = (state_q == StBusy) && (lat_cnt_q == LatMax);
      // rst is also gated here so no grant leaks out combinationally while held in reset
      eligible  = rst && ((state_q == StIdle) || resp);
      starved   = if_req_i && (starve_cnt_q == StarveMax);
      data_win  = eligible && d_req_i && !starved;
      fetch_win = eligible && if_req_i && !data_win;
   end

   always_comb begin
      if_gnt_o    = fetch_win;
      d_gnt_o     = data_win;
      mem_en_o    = data_win || fetch_win;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (data_win) begin
         mem_we_o    = d_we_i;
         mem_be_o    = d_be_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end else if (fetch_win) begin
         mem_be_o    = '1;
         mem_addr_o  = if_addr_i;
      end

      if_rvalid_o = resp && (owner_q == OwnFetch);
      d_rvalid_o  = resp && (owner_q == OwnData);
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
      d_rdata_o   = (d_rvalid_o && !store_q) ? mem_rdata_i : '0;
      busy_o      = (state_q == StBusy);
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      store_d      = store_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;

      if (data_win || fetch_win) begin
         state_d   = StBusy;
         lat_cnt_d = 3'd1;
         owner_d   = data_win ? OwnData : OwnFetch;
         store_d   = data_win && d_we_i;
      end else if (resp) begin
         state_d   = StIdle;
         lat_cnt_d = 3'd0;
      end else if (state_q == StBusy) begin
         lat_cnt_d = lat_cnt_q + 3'd1;
      end

      if (!if_req_i || fetch_win) begin
         starve_cnt_d = '0;
      end else if (data_win && (starve_cnt_q != StarveMax)) begin
         starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         owner_q      <= OwnFetch;
         store_q      <= 1'b0;
         lat_cnt_q    <= 3'd0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         store_q      <= store_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table at MEM_LAT=2, plus starvation
// and mid-access reset sequences (the latter on a MEM_LAT=3 instance).
module tb_mem_arbiter;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;
   localparam int NV = 17;

   logic clk = 1'b0;
   logic rst;
   logic if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0] d_be;

   logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_be;

   logic u3_if_gnt, u3_if_rvalid, u3_d_gnt, u3_d_rvalid, u3_mem_en, u3_mem_we, u3_busy;
   logic [31:0] u3_if_rdata, u3_d_rdata, u3_mem_addr, u3_mem_wdata;
   logic [3:0] u3_mem_be;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(u3_if_gnt),
      .if_rvalid_o(u3_if_rvalid), .if_rdata_o(u3_if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(u3_d_gnt), .d_rvalid_o(u3_d_rvalid),
      .d_rdata_o(u3_d_rdata), .mem_en_o(u3_mem_en), .mem_we_o(u3_mem_we),
      .mem_be_o(u3_mem_be), .mem_addr_o(u3_mem_addr), .mem_wdata_o(u3_mem_wdata),
      .mem_rdata_i(32'hA5A5_A5A5), .busy_o(u3_busy)
   );

   wire [138:0] obs_u = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                         mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy};
   wire [138:0] obs_u3 = {u3_if_gnt, u3_if_rvalid, u3_if_rdata, u3_d_gnt, u3_d_rvalid,
                          u3_d_rdata, u3_mem_en, u3_mem_we, u3_mem_be, u3_mem_addr,
                          u3_mem_wdata, u3_busy};

   // Memory model, 2-cycle read latency; preloaded while reset is held.
   logic [31:0] mem [0:127];
   logic [31:0] rd_pipe0, rd_pipe1;
   assign mem_rdata = rd_pipe1;

   always @(posedge clk) begin
      if (!rst) begin
         mem[4]  <= 32'h0050_0093;
         mem[5]  <= 32'h00A0_0113;
         mem[8]  <= 32'h1122_3344;
         mem[64] <= 32'h1234_5678;
         rd_pipe0 <= 32'h0;
      end else if (mem_en && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_addr[8:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
         rd_pipe0 <= 32'hBAD0_BAD0;
      end else if (mem_en) begin
         rd_pipe0 <= mem[mem_addr[8:2]];
      end else begin
         rd_pipe0 <= 32'hDEAD_0000;
      end
      rd_pipe1 <= rd_pipe0;
   end

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_be;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        e_if_gnt;
      logic        e_d_gnt;
      logic        e_if_rv;
      logic [31:0] e_if_rd;
      logic        e_d_rv;
      logic [31:0] e_d_rd;
      logic        e_en;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic        e_busy;
   } vec_t;

   vec_t vecs [NV];

   function automatic logic [138:0] pack_exp(input vec_t v);
      return {v.e_if_gnt, v.e_if_rv, v.e_if_rd, v.e_d_gnt, v.e_d_rv, v.e_d_rd,
              v.e_en, v.e_we, v.e_be, v.e_addr, v.e_wd, v.e_busy};
   endfunction

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;
      int both;
      int rv_seen;
      logic exp_f [10];
      logic got_f [10];

      // Fetch-only, load+fetch, then store followed back-to-back by a load of the same word.
      vecs[0]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, N};
      vecs[1]  = '{Y, 32'h10, N, N, 4'h0, 32'h0,   32'h0,
                   Y, N, N, 32'h0,         N, 32'h0,         Y, N, 4'hF, 32'h10,  32'h0, N};
      vecs[2]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[3]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, Y, 32'h0050_0093, N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[4]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, N};
      vecs[5]  = '{Y, 32'h14, Y, N, 4'hF, 32'h100, 32'h0,
                   N, Y, N, 32'h0,         N, 32'h0,         Y, N, 4'hF, 32'h100, 32'h0, N};
      vecs[6]  = '{Y, 32'h14, N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[7]  = '{Y, 32'h14, N, N, 4'h0, 32'h0,   32'h0,
                   Y, N, N, 32'h0,         Y, 32'h1234_5678, Y, N, 4'hF, 32'h14,  32'h0, Y};
      vecs[8]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[9]  = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, Y, 32'h00A0_0113, N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[10] = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, N};
      vecs[11] = '{N, 32'h0,  Y, Y, 4'h3, 32'h20,  32'hDEAD_BEEF,
                   N, Y, N, 32'h0,   N, 32'h0,   Y, Y, 4'h3, 32'h20, 32'hDEAD_BEEF, N};
      vecs[12] = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[13] = '{N, 32'h0,  Y, N, 4'hF, 32'h20,  32'h0,
                   N, Y, N, 32'h0,         Y, 32'h0,         Y, N, 4'hF, 32'h20,  32'h0, Y};
      vecs[14] = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[15] = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         Y, 32'h1122_BEEF, N, N, 4'h0, 32'h0,   32'h0, Y};
      vecs[16] = '{N, 32'h0,  N, N, 4'h0, 32'h0,   32'h0,
                   N, N, N, 32'h0,         N, 32'h0,         N, N, 4'h0, 32'h0,   32'h0, N};

      exp_f = '{N, N, N, N, Y, N, N, N, N, Y};

      // Reset held with both requests active: everything must stay 0.
      idle_inputs();
      rst = 0;
      if_req = 1; if_addr = 32'h10; d_req = 1; d_be = 4'hF; d_addr = 32'h100;
      repeat (3) @(negedge clk);
      #2;
      check("reset_outputs", 160'(obs_u), 160'(0));
      check("reset_outputs_lat3", 160'(obs_u3), 160'(0));
      @(negedge clk);
      idle_inputs();
      rst = 1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_be = vecs[i].d_be;
         d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
         #2;
         check($sformatf("vec%0d", i), 160'(obs_u), 160'(pack_exp(vecs[i])));
      end

      // Starvation: both requesters held high continuously.
      @(negedge clk);
      if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
      grants = 0;
      both = 0;
      for (int c = 0; c < 40 && grants < 10; c++) begin
         #2;
         if (if_gnt && d_gnt) both++;
         if (if_gnt || d_gnt) begin
            got_f[grants] = if_gnt;
            grants++;
         end
         @(negedge clk);
      end
      check("starve_grant_count", 160'(grants), 160'(10));
      check("starve_one_gnt", 160'(both), 160'(0));
      for (int k = 0; k < 10; k++) begin
         if (k < grants) check($sformatf("starve_g%0d_is_fetch", k), 160'(got_f[k]),
                               160'(exp_f[k]));
      end
      idle_inputs();
      repeat (6) @(negedge clk);

      // Mid-access reset on the MEM_LAT=3 instance.
      d_req = 1; d_be = 4'hF; d_addr = 32'h100;
      #2;
      check("midrst_gnt", 160'(u3_d_gnt), 160'(1));
      @(negedge clk);
      idle_inputs();
      #2;
      check("midrst_busy_before", 160'(u3_busy), 160'(1));
      #1 rst = 0;
      #1;
      check("midrst_busy_after", 160'(u3_busy), 160'(0));
      check("midrst_outputs_lat3", 160'(obs_u3), 160'(0));
      check("midrst_outputs", 160'(obs_u), 160'(0));
      repeat (2) @(negedge clk);
      rst = 1;
      rv_seen = 0;
      for (int c = 0; c < 6; c++) begin
         #2;
         if (if_rvalid || d_rvalid || u3_if_rvalid || u3_d_rvalid) rv_seen++;
         @(negedge clk);
      end
      check("midrst_no_rvalid", 160'(rv_seen), 160'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
